lsu_mc: RTL



---
 rtl/lsu_mc_pkg.sv | 47 ++++
 rtl/lsu_mc_if.sv | 52 +++++
 rtl/lsu_lane_align.sv | 79 +++++++
 rtl/lsu_mc.sv | 134 +++++++++++++
 4 files changed

// File: rtl/lsu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mc_pkg
// Purpose  : Shared definitions for the multi-cycle load/store unit.
//            Operation codes ({is_store, funct3}), FSM state encoding and
//            the access-width byte-mask helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_mc_pkg;

    // Operation codes, {is_store, funct3}
    localparam logic [3:0] LSU_LB  = 4'b0000;
    localparam logic [3:0] LSU_LH  = 4'b0001;
    localparam logic [3:0] LSU_LW  = 4'b0010;
    localparam logic [3:0] LSU_LD  = 4'b0011;
    localparam logic [3:0] LSU_LBU = 4'b0100;
    localparam logic [3:0] LSU_LHU = 4'b0101;
    localparam logic [3:0] LSU_LWU = 4'b0110;
    localparam logic [3:0] LSU_SB  = 4'b1000;
    localparam logic [3:0] LSU_SH  = 4'b1001;
    localparam logic [3:0] LSU_SW  = 4'b1010;
    localparam logic [3:0] LSU_SD  = 4'b1011;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MREQ  = 3'd1,
        ST_MWAIT = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } lsu_state_e;

    // Byte mask of an access of size 2**size bytes, right-aligned.
    function automatic logic [7:0] lsu_width_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mc_if
// Purpose  : Bundles the pipeline request/response channel and the data
//            memory channel of the load/store unit.
// Ports    : none; modports
//              slave  - the load/store unit itself
//              master - the surrounding pipeline + memory environment
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mc_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    // Pipeline side
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_err;

    // Memory side
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational lane steering for the load/store unit.
//            Computes byte enables and lane-shifted store data, flags
//            illegal or misaligned accesses, and extracts/extends the
//            addressed bytes of a memory read word.
// Ports    : i_op        operation {is_store, funct3}
//            i_off       byte offset within the memory word
//            i_wdata     right-aligned store data
//            i_rdata     full-width memory read word
//            o_be        byte enables
//            o_wdata_sh  store data shifted into lane position
//            o_rdata_ext extracted and sign/zero-extended load data
//            o_misaligned, o_illegal  access fault flags
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_mc_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  wire logic [3:0]      i_op,
    input  wire logic [OFFW-1:0] i_off,
    input  wire logic [XLEN-1:0] i_wdata,
    input  wire logic [XLEN-1:0] i_rdata,
    output logic [NB-1:0]        o_be,
    output logic [XLEN-1:0]      o_wdata_sh,
    output logic [XLEN-1:0]      o_rdata_ext,
    output logic                 o_misaligned,
    output logic                 o_illegal
);

    logic [2:0]      w_off3;
    logic [1:0]      w_size;
    logic [NB-1:0]   w_mask;
    logic [XLEN-1:0] w_rsh;

    assign w_off3 = 3'(i_off);
    assign w_size = i_op[1:0];
    assign w_mask = NB'(lsu_width_mask(w_size));

    // (1 << size) - 1 wraps to 3'b111 for doublewords, so one expression
    // covers every size.
    assign o_misaligned = |(w_off3 & ((3'd1 << w_size) - 3'd1));

    always_comb begin
        o_illegal = 1'b0;
        if (i_op == 4'b0111 || i_op[3:2] == 2'b11) begin
            o_illegal = 1'b1;
        end
        if (XLEN == 32 && (i_op == LSU_LD || i_op == LSU_LWU || i_op == LSU_SD)) begin
            o_illegal = 1'b1;
        end
    end

    assign o_be       = w_mask << i_off;
    assign o_wdata_sh = i_wdata << {i_off, 3'b000};
    assign w_rsh      = i_rdata >> {i_off, 3'b000};

    // Sized casts of signed operands sign-extend; unsigned ones zero-extend.
    always_comb begin
        o_rdata_ext = '0;
        case (i_op[2:0])
            3'b000:  o_rdata_ext = XLEN'($signed(w_rsh[7:0]));
            3'b001:  o_rdata_ext = XLEN'($signed(w_rsh[15:0]));
            3'b010:  o_rdata_ext = XLEN'($signed(w_rsh[31:0]));
            3'b011:  o_rdata_ext = w_rsh;
            3'b100:  o_rdata_ext = XLEN'(w_rsh[7:0]);
            3'b101:  o_rdata_ext = XLEN'(w_rsh[15:0]);
            3'b110:  o_rdata_ext = XLEN'(w_rsh[31:0]);
            default: o_rdata_ext = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mc.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mc
// Purpose  : Multi-cycle load/store unit between execute stage and data
//            memory. One transaction outstanding; faults are answered
//            without touching memory.
// Ports    : clk  system clock
//            rst  asynchronous active-high reset
//            bus  lsu_mc_if.slave - pipeline req/rsp and memory channel
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mc
    import lsu_mc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    lsu_mc_if.slave   bus
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_e        r_state;
    logic [3:0]        r_op;
    logic [OFFW-1:0]   r_off;
    logic              r_mem_req_valid;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [NB-1:0]     r_mem_be;
    logic [XLEN-1:0]   r_mem_wdata;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [XLEN-1:0]   r_rsp_data;

    logic [3:0]        w_op;
    logic [OFFW-1:0]   w_off;
    logic [NB-1:0]     w_be;
    logic [XLEN-1:0]   w_wdata_sh;
    logic [XLEN-1:0]   w_rdata_ext;
    logic              w_misaligned;
    logic              w_illegal;

    // One aligner serves both phases: in IDLE it looks at the incoming
    // request, afterwards at the captured op/offset for load extraction.
    assign w_op  = (r_state == ST_IDLE) ? bus.req_op : r_op;
    assign w_off = (r_state == ST_IDLE) ? bus.req_addr[OFFW-1:0] : r_off;

    lsu_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_op         (w_op),
        .i_off        (w_off),
        .i_wdata      (bus.req_wdata),
        .i_rdata      (bus.mem_rdata),
        .o_be         (w_be),
        .o_wdata_sh   (w_wdata_sh),
        .o_rdata_ext  (w_rdata_ext),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_op            <= '0;
            r_off           <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_be        <= '0;
            r_mem_wdata     <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_err       <= 1'b0;
            r_rsp_data      <= '0;
        end else begin
            // Response strobe lasts exactly one cycle.
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op  <= bus.req_op;
                        r_off <= bus.req_addr[OFFW-1:0];
                        if (w_illegal || w_misaligned) begin
                            r_state     <= ST_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state         <= ST_MREQ;
                            r_mem_req_valid <= 1'b1;
                            r_mem_we        <= bus.req_op[3];
                            r_mem_addr      <= {bus.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                            r_mem_be        <= w_be;
                            r_mem_wdata     <= w_wdata_sh;
                        end
                    end
                end
                ST_MREQ: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_MWAIT;
                    end
                end
                ST_MWAIT: begin
                    if (bus.mem_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_op[3] ? '0 : w_rdata_ext;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Held low during reset so nothing is accepted while rst is high.
    assign bus.req_ready     = (r_state == ST_IDLE) && !rst;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_be        = r_mem_be;
    assign bus.mem_wdata     = r_mem_wdata;

endmodule
`default_nettype wire
